// File: rtl/alu_muldiv_unit_if.sv
// Request/result bundle between the ALU controller and the multiply/divide unit.
// The controller side drives the op request; the unit side returns status and HI/LO.
interface alu_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       MdOp;
    logic             Sign;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output start, MdOp, Sign, A, B,
        input  busy, done, HI, LO
    );

    modport slave (
        input  start, MdOp, Sign, A, B,
        output busy, done, HI, LO
    );
endinterface

// File: rtl/alu_muldiv_unit.sv
// Iterative multiply (shift-add) / restoring divide unit with HI/LO result registers.
// Operands are processed as magnitudes; signs are reapplied in a single fixup cycle.
module alu_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    alu_muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT = 3'b001;
    localparam logic [2:0] OP_DIV  = 3'b010;
    localparam logic [2:0] OP_MTHI = 3'b011;
    localparam logic [2:0] OP_MTLO = 3'b100;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        if (sgn && v[WIDTH-1]) begin
            magnitude = {WIDTH{1'b0}} - v;
        end else begin
            magnitude = v;
        end
    endfunction

    logic [1:0]       state_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic             is_div_r;
    logic             neg_res_r;
    logic             neg_rem_r;
    logic             div_zero_r;
    logic [WIDTH-1:0] acc_r;    // product high half / remainder
    logic [WIDTH-1:0] low_r;    // multiplier->product low half / dividend->quotient
    logic [WIDTH-1:0] opnd_r;   // multiplicand / divisor
    logic [WIDTH-1:0] a_raw_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    logic             launch_s;
    logic [WIDTH:0]   mul_sum_s;
    logic [WIDTH:0]   div_shift_s;
    logic [WIDTH:0]   div_diff_s;
    logic             div_bit_s;
    logic [WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0] low_next_s;
    logic [WIDTH-1:0] hi_fix_s;
    logic [WIDTH-1:0] lo_fix_s;

    // Accept a MULT/DIV only from IDLE; anything arriving while busy is dropped.
    always_comb begin
        launch_s = 1'b0;
        if (state_r == ST_IDLE && bus.start &&
            (bus.MdOp == OP_MULT || bus.MdOp == OP_DIV)) begin
            launch_s = 1'b1;
        end else begin
            launch_s = 1'b0;
        end
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r} + (low_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_r, low_r[WIDTH-1]};
        if (div_shift_s >= {1'b0, opnd_r}) begin
            div_diff_s = div_shift_s - {1'b0, opnd_r};
            div_bit_s  = 1'b1;
        end else begin
            div_diff_s = div_shift_s;
            div_bit_s  = 1'b0;
        end
        if (is_div_r) begin
            acc_next_s = div_diff_s[WIDTH-1:0];
            low_next_s = {low_r[WIDTH-2:0], div_bit_s};
        end else begin
            acc_next_s = mul_sum_s[WIDTH:1];
            low_next_s = {mul_sum_s[0], low_r[WIDTH-1:1]};
        end
    end

    // Sign fixup; divide-by-zero bypasses it and reports the raw dividend in HI.
    always_comb begin
        hi_fix_s = acc_r;
        lo_fix_s = low_r;
        if (is_div_r) begin
            if (div_zero_r) begin
                hi_fix_s = a_raw_r;
                lo_fix_s = {WIDTH{1'b1}};
            end else begin
                hi_fix_s = neg_rem_r ? ({WIDTH{1'b0}} - acc_r) : acc_r;
                lo_fix_s = neg_res_r ? ({WIDTH{1'b0}} - low_r) : low_r;
            end
        end else begin
            if (neg_res_r) begin
                {hi_fix_s, lo_fix_s} = {(2*WIDTH){1'b0}} - {acc_r, low_r};
            end else begin
                {hi_fix_s, lo_fix_s} = {acc_r, low_r};
            end
        end
    end

    // Control FSM: IDLE -> CALC (WIDTH cycles) -> FIX -> IDLE with done pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (launch_s) begin
                        state_r <= ST_CALC;
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: operand capture, iteration, HI/LO writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            is_div_r   <= 1'b0;
            neg_res_r  <= 1'b0;
            neg_rem_r  <= 1'b0;
            div_zero_r <= 1'b0;
            acc_r      <= {WIDTH{1'b0}};
            low_r      <= {WIDTH{1'b0}};
            opnd_r     <= {WIDTH{1'b0}};
            a_raw_r    <= {WIDTH{1'b0}};
            hi_r       <= {WIDTH{1'b0}};
            lo_r       <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.MdOp)
                            OP_MULT, OP_DIV: begin
                                is_div_r   <= (bus.MdOp == OP_DIV);
                                neg_res_r  <= bus.Sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                                neg_rem_r  <= bus.Sign & bus.A[WIDTH-1];
                                div_zero_r <= (bus.MdOp == OP_DIV) && (bus.B == {WIDTH{1'b0}});
                                acc_r      <= {WIDTH{1'b0}};
                                low_r      <= magnitude(bus.A, bus.Sign);
                                opnd_r     <= magnitude(bus.B, bus.Sign);
                                a_raw_r    <= bus.A;
                            end
                            OP_MTHI: hi_r <= bus.A;
                            OP_MTLO: lo_r <= bus.A;
                            default: ;
                        endcase
                    end
                end
                ST_CALC: begin
                    acc_r <= acc_next_s;
                    low_r <= low_next_s;
                end
                ST_FIX: begin
                    hi_r <= hi_fix_s;
                    lo_r <= lo_fix_s;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.HI   = hi_r;
    assign bus.LO   = lo_r;
endmodule
